// File: rtl/studio2_pkg.sv
// Shared types, scancode tables and helpers for the Studio II keypad front end.
package studio2_pkg;

  typedef logic [3:0] key_idx_t;

  localparam key_idx_t   KEY_NONE = 4'hF;
  localparam logic [2:0] SEL_PORT = 3'd2;
  localparam int         NUM_KEYS = 10;

  // Set-2 make codes; index in the table is the keypad key number.
  localparam logic [7:0] KP1_CODES [NUM_KEYS] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };
  localparam logic [7:0] KP2_CODES [NUM_KEYS] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  typedef enum logic [1:0] {
    CELL_IDLE,
    CELL_HELD,
    CELL_RELEASING
  } cell_state_t;

  typedef struct packed {
    logic     hit;
    logic     pad;   // 0 = keypad 1, 1 = keypad 2
    key_idx_t idx;
  } key_map_t;

  function automatic key_map_t decode_scancode(input logic [7:0] code);
    key_map_t m;
    m = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (code == KP1_CODES[k]) m = '{hit: 1'b1, pad: 1'b0, idx: key_idx_t'(k)};
      if (code == KP2_CODES[k]) m = '{hit: 1'b1, pad: 1'b1, idx: key_idx_t'(k)};
    end
    return m;
  endfunction

  // Indices 10..15 fall into the zero padding, so they never report a held key.
  function automatic logic key_selected(input logic [NUM_KEYS-1:0] state,
                                        input key_idx_t            sel);
    logic [15:0] padded;
    padded = {6'b0, state};
    return padded[sel];
  endfunction

endpackage

// File: rtl/studio2_key_cell.sv
// One keypad key: tracks make/break events and stretches a release by HOLD cycles.
module studio2_key_cell
  import studio2_pkg::*;
#(
  parameter int unsigned HOLD = 16'd2048,
  parameter int          HW   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic make,
  input  logic brk,
  output logic held
);

  cell_state_t   state;
  logic [HW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every cell samples
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CELL_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        CELL_IDLE: begin
          if (make) state <= CELL_HELD;
        end
        CELL_HELD: begin
          if (brk) begin
            if (HOLD == 0) begin
              state <= CELL_IDLE;
            end else begin
              state <= CELL_RELEASING;
              cnt   <= HW'(HOLD);
            end
          end
        end
        CELL_RELEASING: begin
          if (make) begin
            state <= CELL_HELD;
            cnt   <= '0;
          end else if (cnt == HW'(1)) begin
            state <= CELL_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - HW'(1);
          end
        end
        default: begin
          state <= CELL_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign held = (state != CELL_IDLE);

endmodule

// File: rtl/studio2_keypad.sv
// PS/2 keyboard to Studio II keypad bridge: decodes key events into 20 held-key
// cells, latches the CPU's OUT 2 key index and drives the active-low EF3/EF4 flags.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int unsigned HOLD = 16'd2048,
  parameter int          HW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         ps2_key,
  input  logic                io_out,
  input  logic [2:0]          io_n,
  input  logic [7:0]          io_dout,
  output logic                ef3_n,
  output logic                ef4_n,
  output logic [NUM_KEYS-1:0] kp1_state,
  output logic [NUM_KEYS-1:0] kp2_state,
  output key_idx_t            key_sel
);

  logic                          toggle_q;
  logic                          key_event;
  key_map_t                      key_map;
  logic [1:0][NUM_KEYS-1:0]      make_v;
  logic [1:0][NUM_KEYS-1:0]      brk_v;
  logic [1:0][NUM_KEYS-1:0]      held_v;

  // NOTE: no reset here on purpose: the flop follows ps2_key[10] every cycle,
  // including while reset is held, so leaving reset never sees a stale toggle.
  always_ff @(posedge clk) begin
    toggle_q <= ps2_key[10];
  end

  assign key_event = toggle_q ^ ps2_key[10];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    make_v  = '0;
    brk_v   = '0;
    key_map = decode_scancode(ps2_key[7:0]);
    if (key_event && !ps2_key[8] && key_map.hit) begin
      if (ps2_key[9]) make_v[key_map.pad][key_map.idx] = 1'b1;
      else            brk_v[key_map.pad][key_map.idx]  = 1'b1;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pad
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      studio2_key_cell #(
        .HOLD (HOLD),
        .HW   (HW)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .make  (make_v[p][k]),
        .brk   (brk_v[p][k]),
        .held  (held_v[p][k])
      );
    end
  end

  assign kp1_state = held_v[0];
  assign kp2_state = held_v[1];

  // EF sees the selection and key state from before this edge, giving the
  // documented one-cycle lag behind either input without any priority logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sel <= KEY_NONE;
      ef3_n   <= 1'b1;
      ef4_n   <= 1'b1;
    end else begin
      if (io_out && io_n == SEL_PORT) key_sel <= io_dout[3:0];
      ef3_n <= ~key_selected(kp1_state, key_sel);
      ef4_n <= ~key_selected(kp2_state, key_sel);
    end
  end

endmodule

// File: tb/tb_studio2_keypad.sv
// Self-checking bench for studio2_keypad: directed scenarios plus random traffic
// compared against a press/release-deadline model of the keypads.
module tb_studio2_keypad;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        io_out = 1'b0;
  logic [2:0]  io_n = '0;
  logic [7:0]  io_dout = '0;
  logic        ef3_n, ef4_n;
  logic [9:0]  kp1_state, kp2_state;
  logic [3:0]  key_sel;

  int checks = 0;
  int errors = 0;

  studio2_keypad #(.HOLD(HOLD), .HW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .io_out    (io_out),
    .io_n      (io_n),
    .io_dout   (io_dout),
    .ef3_n     (ef3_n),
    .ef4_n     (ef4_n),
    .kp1_state (kp1_state),
    .kp2_state (kp2_state),
    .key_sel   (key_sel)
  );

  always #5 clk = ~clk;

  logic [7:0] kp_codes [2][10] = '{
    '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
    '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D}
  };
  logic [7:0] unmapped [4] = '{8'h1C, 8'h00, 8'hF0, 8'h12};

  // Model: a key is held while physically pressed or until its release deadline.
  bit         m_pressed [2][10];
  int         m_rel_at  [2][10];
  int         edge_n;
  logic [3:0] m_sel;
  logic       m_ef3, m_ef4, m_tog;

  function automatic bit m_held(int p, int k);
    if (k > 9) return 1'b0;
    return m_pressed[p][k] || (edge_n < m_rel_at[p][k]);
  endfunction

  function automatic logic [9:0] m_state(int p);
    logic [9:0] s;
    for (int k = 0; k < 10; k++) s[k] = m_held(p, k);
    return s;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 10; k++) begin
        m_pressed[p][k] = 1'b0;
        m_rel_at[p][k]  = 0;
      end
    m_sel = 4'hF;
    m_ef3 = 1'b1;
    m_ef4 = 1'b1;
    m_tog = ps2_key[10];
  endtask

  task automatic send(input logic [7:0] code, input bit pressed, input bit ext);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic out_port(input logic [2:0] n, input logic [7:0] data);
    io_out  = 1'b1;
    io_n    = n;
    io_dout = data;
  endtask

  // Advance the model across one clock edge, then let the DUT take that edge.
  task automatic step();
    m_ef3 = !(m_sel < 10 && m_held(0, int'(m_sel)));
    m_ef4 = !(m_sel < 10 && m_held(1, int'(m_sel)));
    if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
    edge_n++;
    if (ps2_key[10] != m_tog) begin
      m_tog = ps2_key[10];
      if (!ps2_key[8])
        for (int p = 0; p < 2; p++)
          for (int k = 0; k < 10; k++)
            if (ps2_key[7:0] == kp_codes[p][k]) begin
              if (ps2_key[9]) m_pressed[p][k] = 1'b1;
              else if (m_pressed[p][k]) begin
                m_pressed[p][k] = 1'b0;
                m_rel_at[p][k]  = edge_n + HOLD;
              end
            end
    end
    @(posedge clk);
    #1;
    io_out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks += 5;
    if (kp1_state !== 10'h000) begin errors++; $display("FAIL reset_kp1 got=%h exp=000", kp1_state); end
    if (kp2_state !== 10'h000) begin errors++; $display("FAIL reset_kp2 got=%h exp=000", kp2_state); end
    if (key_sel !== 4'hF)      begin errors++; $display("FAIL reset_sel got=%h exp=F", key_sel); end
    if (ef3_n !== 1'b1)        begin errors++; $display("FAIL reset_ef3 got=%b exp=1", ef3_n); end
    if (ef4_n !== 1'b1)        begin errors++; $display("FAIL reset_ef4 got=%b exp=1", ef4_n); end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (kp1_state !== 10'h000 || kp2_state !== 10'h000) begin
      errors++; $display("FAIL reset_release got=%h/%h exp=000/000", kp1_state, kp2_state);
    end
  endtask

  task automatic test_select_and_make();
    out_port(3'd2, 8'h05);
    step();
    checks++;
    if (key_sel !== m_sel) begin errors++; $display("FAIL sel_latch got=%h exp=%h", key_sel, m_sel); end
    send(8'h2E, 1'b1, 1'b0);
    step();
    checks += 2;
    if (kp1_state !== m_state(0)) begin errors++; $display("FAIL make_kp1 got=%h exp=%h", kp1_state, m_state(0)); end
    if (ef3_n !== m_ef3) begin errors++; $display("FAIL make_ef3_early got=%b exp=%b", ef3_n, m_ef3); end
    step();
    checks += 2;
    if (ef3_n !== m_ef3) begin errors++; $display("FAIL make_ef3 got=%b exp=%b", ef3_n, m_ef3); end
    if (ef4_n !== m_ef4) begin errors++; $display("FAIL make_ef4 got=%b exp=%b", ef4_n, m_ef4); end
  endtask

  task automatic test_hold_release();
    send(8'h2E, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      checks += 2;
      if (ef3_n !== m_ef3) begin errors++; $display("FAIL hold_ef3 cyc=%0d got=%b exp=%b", i, ef3_n, m_ef3); end
      if (kp1_state !== m_state(0)) begin errors++; $display("FAIL hold_kp1 cyc=%0d got=%h exp=%h", i, kp1_state, m_state(0)); end
    end
    send(8'h2E, 1'b1, 1'b0);
    step();
    step();
    send(8'h2E, 1'b0, 1'b0);
    step();
    step();
    send(8'h2E, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks += 2;
      if (ef3_n !== m_ef3) begin errors++; $display("FAIL remake_ef3 cyc=%0d got=%b exp=%b", i, ef3_n, m_ef3); end
      if (kp1_state !== m_state(0)) begin errors++; $display("FAIL remake_kp1 cyc=%0d got=%h exp=%h", i, kp1_state, m_state(0)); end
    end
  endtask

  task automatic test_kp2_select();
    out_port(3'd2, 8'h08);
    send(8'h75, 1'b1, 1'b0);
    step();
    step();
    step();
    checks++;
    if (ef4_n !== m_ef4) begin errors++; $display("FAIL kp2_ef4 got=%b exp=%b", ef4_n, m_ef4); end
    out_port(3'd2, 8'h0A);
    step();
    step();
    checks += 3;
    if (ef4_n !== m_ef4) begin errors++; $display("FAIL desel_ef4 got=%b exp=%b", ef4_n, m_ef4); end
    if (ef3_n !== m_ef3) begin errors++; $display("FAIL desel_ef3 got=%b exp=%b", ef3_n, m_ef3); end
    if (kp2_state !== m_state(1)) begin errors++; $display("FAIL desel_kp2 got=%h exp=%h", kp2_state, m_state(1)); end
  endtask

  task automatic test_ignored();
    send(8'h75, 1'b0, 1'b1);
    step();
    send(8'h1C, 1'b1, 1'b0);
    step();
    step();
    checks += 4;
    if (kp1_state !== m_state(0)) begin errors++; $display("FAIL ign_kp1 got=%h exp=%h", kp1_state, m_state(0)); end
    if (kp2_state !== m_state(1)) begin errors++; $display("FAIL ign_kp2 got=%h exp=%h", kp2_state, m_state(1)); end
    if (ef3_n !== m_ef3) begin errors++; $display("FAIL ign_ef3 got=%b exp=%b", ef3_n, m_ef3); end
    if (ef4_n !== m_ef4) begin errors++; $display("FAIL ign_ef4 got=%b exp=%b", ef4_n, m_ef4); end
  endtask

  task automatic test_async_reset();
    out_port(3'd2, 8'h01);
    send(8'h16, 1'b1, 1'b0);
    step();
    send(8'h16, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (ef3_n !== m_ef3) begin errors++; $display("FAIL pre_reset_ef3 got=%b exp=%b", ef3_n, m_ef3); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks += 5;
    if (kp1_state !== 10'h000) begin errors++; $display("FAIL async_kp1 got=%h exp=000", kp1_state); end
    if (kp2_state !== 10'h000) begin errors++; $display("FAIL async_kp2 got=%h exp=000", kp2_state); end
    if (key_sel !== 4'hF)      begin errors++; $display("FAIL async_sel got=%h exp=F", key_sel); end
    if (ef3_n !== 1'b1)        begin errors++; $display("FAIL async_ef3 got=%b exp=1", ef3_n); end
    if (ef4_n !== 1'b1)        begin errors++; $display("FAIL async_ef4 got=%b exp=1", ef4_n); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (kp1_state !== m_state(0)) begin errors++; $display("FAIL post_reset_kp1 got=%h exp=%h", kp1_state, m_state(0)); end
      if (ef3_n !== m_ef3) begin errors++; $display("FAIL post_reset_ef3 got=%b exp=%b", ef3_n, m_ef3); end
      if (key_sel !== m_sel) begin errors++; $display("FAIL post_reset_sel got=%h exp=%h", key_sel, m_sel); end
    end
  endtask

  task automatic test_other_port();
    out_port(3'd4, 8'h03);
    step();
    step();
    checks++;
    if (key_sel !== m_sel) begin errors++; $display("FAIL port4_sel got=%h exp=%h", key_sel, m_sel); end
  endtask

  task automatic test_back_to_back();
    out_port(3'd2, 8'h03);
    send(8'h26, 1'b1, 1'b0);
    step();
    send(8'h25, 1'b1, 1'b0);
    step();
    send(8'h26, 1'b0, 1'b0);
    step();
    checks++;
    if (kp1_state !== m_state(0)) begin errors++; $display("FAIL b2b_kp1 got=%h exp=%h", kp1_state, m_state(0)); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks += 2;
      if (kp1_state !== m_state(0)) begin errors++; $display("FAIL b2b_kp1_tail cyc=%0d got=%h exp=%h", i, kp1_state, m_state(0)); end
      if (ef3_n !== m_ef3) begin errors++; $display("FAIL b2b_ef3 cyc=%0d got=%b exp=%b", i, ef3_n, m_ef3); end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] code;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 23);
        code = (r < 10) ? kp_codes[0][r] : (r < 20) ? kp_codes[1][r-10] : unmapped[r-20];
        send(code, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 5) == 0)
        out_port(($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)));
      step();
      checks += 5;
      if (kp1_state !== m_state(0)) begin errors++; $display("FAIL rnd_kp1 i=%0d got=%h exp=%h", i, kp1_state, m_state(0)); end
      if (kp2_state !== m_state(1)) begin errors++; $display("FAIL rnd_kp2 i=%0d got=%h exp=%h", i, kp2_state, m_state(1)); end
      if (key_sel !== m_sel) begin errors++; $display("FAIL rnd_sel i=%0d got=%h exp=%h", i, key_sel, m_sel); end
      if (ef3_n !== m_ef3) begin errors++; $display("FAIL rnd_ef3 i=%0d got=%b exp=%b", i, ef3_n, m_ef3); end
      if (ef4_n !== m_ef4) begin errors++; $display("FAIL rnd_ef4 i=%0d got=%b exp=%b", i, ef4_n, m_ef4); end
    end
  endtask

  initial begin
    edge_n = 0;
    test_reset();
    test_select_and_make();
    test_hold_release();
    test_kp2_select();
    test_ignored();
    test_async_reset();
    test_other_port();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
